operand_bypass_net: RTL and testbench



---
 rtl/operand_bypass_net.sv | 96 +++++++++
 tb/tb_operand_bypass_net.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bypass_net.sv
// Operand forwarding network for the pipelined Beta core: tracks in-flight
// destination tags, forwards Y/PC-link values to decode ports, stalls on load-use.
module operand_bypass_net #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AW         = 5,
  parameter int unsigned NPORTS     = 2,
  parameter int unsigned NSTAGES    = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_rc,
  input  logic [1:0]                issue_kind,
  input  logic                      flush,
  input  logic [NPORTS-1:0]         rd_en,
  input  logic [NPORTS*AW-1:0]      rd_ra,
  input  logic [NPORTS*XLEN-1:0]    rf_data,
  input  logic [NSTAGES*XLEN-1:0]   stage_y,
  input  logic [NSTAGES*XLEN-1:0]   stage_pc,
  output logic [NPORTS*XLEN-1:0]    rd_out,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_count
);

  typedef enum logic [1:0] {
    K_NONE = 2'b00,
    K_ALU  = 2'b01,
    K_LINK = 2'b10,
    K_LOAD = 2'b11
  } kind_t;

  localparam logic [AW-1:0] R31 = '1;

  logic [NSTAGES-1:0] r_valid;
  logic [AW-1:0]      r_rc   [NSTAGES];
  kind_t              r_kind [NSTAGES];
  logic [CNT_W-1:0]   r_cnt;

  logic               w_issue;
  logic [NPORTS-1:0]  w_hit;
  logic [NPORTS-1:0]  w_haz;

  assign w_issue     = issue_valid && !stall && !flush;
  assign stall       = |w_haz;
  assign stall_count = r_cnt;

  // Stages always advance; a stall or flush only turns the EX slot into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int unsigned i = 0; i < NSTAGES; i++) begin
        r_rc[i]   <= '0;
        r_kind[i] <= K_NONE;
      end
    end else begin
      r_valid[0] <= w_issue;
      r_rc[0]    <= issue_rc;
      r_kind[0]  <= kind_t'(issue_kind);
      for (int unsigned i = 1; i < NSTAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_rc[i]    <= r_rc[i-1];
        r_kind[i]  <= r_kind[i-1];
      end
      if (stall && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Youngest match wins; hazard is judged on the winning entry only, so a
  // younger non-load write shadows an older load.
  always_comb begin
    rd_out = '0;
    w_hit  = '0;
    w_haz  = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      rd_out[p*XLEN +: XLEN] = rf_data[p*XLEN +: XLEN];
      if (rd_ra[p*AW +: AW] == R31) begin
        rd_out[p*XLEN +: XLEN] = '0;
      end else begin
        for (int unsigned i = 0; i < NSTAGES; i++) begin
          if (!w_hit[p] && r_valid[i] && (r_kind[i] != K_NONE) &&
              (r_rc[i] == rd_ra[p*AW +: AW])) begin
            w_hit[p] = 1'b1;
            rd_out[p*XLEN +: XLEN] = (r_kind[i] == K_LINK) ? stage_pc[i*XLEN +: XLEN]
                                                          : stage_y[i*XLEN +: XLEN];
            w_haz[p] = rd_en[p] && (r_kind[i] == K_LOAD) && (i < LOAD_READY);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_bypass_net.sv
// Bench for operand_bypass_net: directed and random stimulus against an
// in-flight instruction list model; a second instance exercises counter saturation.
module tb_operand_bypass_net;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NP   = 2;
  localparam int NS   = 3;
  localparam int LR   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic [AW-1:0]     issue_rc;
  logic [1:0]        issue_kind;
  logic              flush;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_ra;
  logic [NP*XLEN-1:0] rf_data;
  logic [NS*XLEN-1:0] stage_y;
  logic [NS*XLEN-1:0] stage_pc;
  logic [NP*XLEN-1:0] rd_out, rd_out_b;
  logic              stall, stall_b;
  logic [15:0]       stall_count;
  logic [1:0]        stall_count_b;

  always #5 clk = ~clk;

  operand_bypass_net #(.XLEN(XLEN), .AW(AW), .NPORTS(NP), .NSTAGES(NS),
                       .LOAD_READY(LR), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rc(issue_rc),
    .issue_kind(issue_kind), .flush(flush), .rd_en(rd_en), .rd_ra(rd_ra),
    .rf_data(rf_data), .stage_y(stage_y), .stage_pc(stage_pc),
    .rd_out(rd_out), .stall(stall), .stall_count(stall_count));

  operand_bypass_net #(.XLEN(XLEN), .AW(AW), .NPORTS(NP), .NSTAGES(NS),
                       .LOAD_READY(LR), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rc(issue_rc),
    .issue_kind(issue_kind), .flush(flush), .rd_en(rd_en), .rd_ra(rd_ra),
    .rf_data(rf_data), .stage_y(stage_y), .stage_pc(stage_pc),
    .rd_out(rd_out_b), .stall(stall_b), .stall_count(stall_count_b));

  // Model: list of in-flight instructions, index 0 = EX.
  bit mv    [NS];
  int mrc   [NS];
  int mkind [NS];
  int cnt_a, cnt_b;
  int checks, failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_port(input int p, output logic [31:0] val, output bit haz);
    int ra;
    ra  = int'(rd_ra[p*AW +: AW]);
    val = rf_data[p*XLEN +: XLEN];
    haz = 1'b0;
    if (ra == 31) begin
      val = 32'h0;
      return;
    end
    for (int i = 0; i < NS; i++) begin
      if (mv[i] && mkind[i] != 0 && mrc[i] == ra) begin
        val = (mkind[i] == 2) ? stage_pc[i*XLEN +: XLEN] : stage_y[i*XLEN +: XLEN];
        haz = rd_en[p] && (mkind[i] == 3) && (i < LR);
        return;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mv[i] = 1'b0; mrc[i] = 0; mkind[i] = 0;
    end
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // Check outputs mid-cycle, then advance model and DUT by one clock.
  task automatic cyc();
    logic [31:0] v;
    bit h, ms;
    ms = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      model_port(p, v, h);
      if (!h) begin
        chk($sformatf("rd_out%0d", p), rd_out[p*XLEN +: XLEN], v);
        chk($sformatf("rd_out_b%0d", p), rd_out_b[p*XLEN +: XLEN], v);
      end
      ms |= h;
    end
    chk("stall", {31'b0, stall}, {31'b0, ms});
    chk("stall_b", {31'b0, stall_b}, {31'b0, ms});
    chk("stall_count", {16'b0, stall_count}, 32'(cnt_a));
    chk("stall_count_b", {30'b0, stall_count_b}, 32'(cnt_b));
    @(posedge clk);
    if (ms) begin
      if (cnt_a < 65535) cnt_a++;
      if (cnt_b < 3) cnt_b++;
    end
    for (int i = NS-1; i >= 1; i--) begin
      mv[i] = mv[i-1]; mrc[i] = mrc[i-1]; mkind[i] = mkind[i-1];
    end
    mv[0]    = issue_valid && !ms && !flush;
    mrc[0]   = int'(issue_rc);
    mkind[0] = int'(issue_kind);
    @(negedge clk);
  endtask

  task automatic randomize_data();
    rf_data  = {$urandom(), $urandom()};
    stage_y  = {$urandom(), $urandom(), $urandom()};
    stage_pc = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic drive(input bit iv, input int rc, input int kind, input bit fl,
                       input bit [1:0] en, input int ra0, input int ra1);
    issue_valid = iv;
    issue_rc    = AW'(rc);
    issue_kind  = 2'(kind);
    flush       = fl;
    rd_en       = en;
    rd_ra       = {AW'(ra1), AW'(ra0)};
    randomize_data();
    cyc();
  endtask

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 9));
    return (r > 7) ? 31 : r;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rc = '0; issue_kind = '0; flush = 1'b0;
    rd_en = '0; rd_ra = '0;
    randomize_data();
    model_reset();
    #3;
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_count", {16'b0, stall_count}, 32'h0);
    chk("reset_rd_out0", rd_out[31:0], rf_data[31:0]);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ALU
    drive(1, 3, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 3, 0);
    // priority: EX over MEM, then MEM after a bubble
    drive(1, 5, 1, 0, 2'b00, 0, 0);
    drive(1, 5, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 5, 0);
    drive(0, 0, 0, 0, 2'b01, 5, 0);
    // link and zero register
    drive(1, 28, 2, 0, 2'b00, 0, 0);
    drive(1, 31, 1, 0, 2'b01, 28, 0);
    drive(0, 0, 0, 0, 2'b11, 31, 31);
    // load-use: two stall cycles, then forwarded from WB
    drive(1, 7, 3, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 7, 0);
    drive(0, 0, 0, 0, 2'b01, 7, 0);
    drive(0, 0, 0, 0, 2'b01, 7, 0);
    // rd_en=0 never stalls
    drive(1, 8, 3, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b00, 8, 8);
    // younger ALU shadows older load
    drive(1, 6, 3, 0, 2'b00, 0, 0);
    drive(1, 6, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b11, 6, 6);
    // flush annuls the issue
    drive(1, 9, 1, 1, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 9, 0);
    // flush during stall still counts
    drive(1, 10, 3, 0, 2'b00, 0, 0);
    drive(1, 11, 1, 1, 2'b10, 0, 10);
    drive(0, 0, 0, 0, 2'b10, 0, 10);
    drive(0, 0, 0, 0, 2'b10, 0, 11);
    // more load-use to saturate the narrow counter
    for (int k = 0; k < 2; k++) begin
      drive(1, 12, 3, 0, 2'b00, 0, 0);
      drive(1, 13, 1, 0, 2'b01, 12, 0);
      drive(1, 13, 1, 0, 2'b01, 12, 0);
      drive(0, 0, 0, 0, 2'b01, 12, 0);
    end

    // random phase
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 1)), pick_reg(), int'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
            pick_reg(), pick_reg());
    end

    // asynchronous reset in the middle of a stall
    drive(1, 7, 3, 0, 2'b00, 0, 0);
    issue_valid = 1'b1; issue_rc = 5'd14; issue_kind = 2'b01; flush = 1'b0;
    rd_en = 2'b01; rd_ra = {5'd0, 5'd7};
    randomize_data();
    #1;
    chk("pre_reset_stall", {31'b0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midstall_reset_stall", {31'b0, stall}, 32'h0);
    chk("midstall_reset_stall_b", {31'b0, stall_b}, 32'h0);
    chk("midstall_reset_count", {16'b0, stall_count}, 32'h0);
    chk("midstall_reset_count_b", {30'b0, stall_count_b}, 32'h0);
    chk("midstall_reset_rd_out0", rd_out[31:0], rf_data[31:0]);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 7, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b01, 7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
